// File: rtl/game_pkg.sv
// rtl/game_pkg.sv - shared state encoding, coordinate type and geometry defaults
package game_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        HIT  = 2'd2,
        OVER = 2'd3
    } state_t;

    typedef logic [9:0] coord_t;

    localparam int SCREEN_WIDTH      = 640;
    localparam int SCREEN_HEIGHT_DEF = 480;
    localparam int PIPE_WIDTH_DEF    = 50;
    localparam int BIRD_WIDTH_DEF    = 20;
    localparam int BIRD_HEIGHT_DEF   = 20;
    localparam int BIRD_X_DEF        = 100;
    localparam int LIVES_DEF         = 3;

endpackage

// File: rtl/multi_pipe_game_controller_if.sv
// rtl/multi_pipe_game_controller_if.sv - motion-side inputs and HUD-side outputs of the controller
// Optional lives signal present when GAME_LIVES_EN is defined.
interface multi_pipe_game_controller_if #(
    parameter int NUM_PIPES = 3,
    parameter int SCORE_W   = 8
) ();
    import game_pkg::*;

    logic                    start_button;
    logic                    frame_tick;
    coord_t                  bird_y;
    logic [NUM_PIPES*10-1:0] pipe_x;
    logic [NUM_PIPES*10-1:0] gap_top;
    logic [NUM_PIPES*10-1:0] gap_bot;
    logic                    collision_out;
    logic [1:0]              state;
    logic [SCORE_W-1:0]      score;
    logic                    game_over;
`ifdef GAME_LIVES_EN
    logic [1:0]              lives;
`endif

    modport master (
        output start_button, frame_tick, bird_y, pipe_x, gap_top, gap_bot,
`ifdef GAME_LIVES_EN
        input  lives,
`endif
        input  collision_out, state, score, game_over
    );

    modport slave (
        input  start_button, frame_tick, bird_y, pipe_x, gap_top, gap_bot,
`ifdef GAME_LIVES_EN
        output lives,
`endif
        output collision_out, state, score, game_over
    );

endinterface

// File: rtl/pipe_collider.sv
// rtl/pipe_collider.sv - combinational hit / passed test of the bird against one pipe column
module pipe_collider
    import game_pkg::*;
#(
    parameter int PIPE_WIDTH  = PIPE_WIDTH_DEF,
    parameter int BIRD_X      = BIRD_X_DEF,
    parameter int BIRD_WIDTH  = BIRD_WIDTH_DEF,
    parameter int BIRD_HEIGHT = BIRD_HEIGHT_DEF
) (
    input  coord_t pipe_x_i,
    input  coord_t gap_top_i,
    input  coord_t gap_bot_i,
    input  coord_t bird_y_i,
    output logic   hit_o,
    output logic   pass_now_o
);

    logic [10:0] pipe_right;
    logic [10:0] bird_bot;
    logic        x_overlap;
    logic        outside_gap;

    // 11-bit sums so edges near the right/bottom of the screen never wrap
    assign pipe_right  = {1'b0, pipe_x_i} + 11'(PIPE_WIDTH);
    assign bird_bot    = {1'b0, bird_y_i} + 11'(BIRD_HEIGHT);

    assign x_overlap   = ({1'b0, pipe_x_i} < 11'(BIRD_X + BIRD_WIDTH)) &&
                         (11'(BIRD_X) < pipe_right);
    assign outside_gap = (bird_y_i < gap_top_i) || (bird_bot > {1'b0, gap_bot_i});

    assign hit_o       = x_overlap && outside_gap;
    assign pass_now_o  = pipe_right < 11'(BIRD_X);

endmodule

// File: rtl/multi_pipe_game_controller.sv
// rtl/multi_pipe_game_controller.sv - game FSM, registered collision and per-pipe pass scoring
// Lives support (port, reload, HIT->PLAY return) is built when GAME_LIVES_EN is defined.
module multi_pipe_game_controller
    import game_pkg::*;
#(
    parameter int SCREEN_HEIGHT = SCREEN_HEIGHT_DEF,
    parameter int PIPE_WIDTH    = PIPE_WIDTH_DEF,
    parameter int BIRD_WIDTH    = BIRD_WIDTH_DEF,
    parameter int BIRD_HEIGHT   = BIRD_HEIGHT_DEF,
    parameter int BIRD_X        = BIRD_X_DEF,
`ifdef GAME_LIVES_EN
    parameter int LIVES         = LIVES_DEF,
`endif
    parameter int NUM_PIPES     = 3,
    parameter int SCORE_W       = 8,
    parameter int HIT_FRAMES    = 30
) (
    input  logic                          clk,
    input  logic                          reset,
    multi_pipe_game_controller_if.slave   bus
);

    localparam int CNT_W = $clog2(HIT_FRAMES + 1);
    localparam int SUM_W = SCORE_W + 4;
    localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

    state_t               state_q, state_d;
    logic                 start_q;
    logic                 start_edge;
    logic                 collision_q, collision_d;
    logic [SCORE_W-1:0]   score_q, score_d;
    logic                 game_over_q, game_over_d;
    logic [NUM_PIPES-1:0] passed_q, passed_d;
    logic [NUM_PIPES-1:0] hit_vec, pass_now;
    logic [CNT_W-1:0]     hit_cnt_q, hit_cnt_d;
    logic [SUM_W-1:0]     pass_cnt, score_sum;
    logic [10:0]          bird_bot;
    logic                 bounds_hit;
`ifdef GAME_LIVES_EN
    logic [1:0]           lives_q, lives_d;
`endif

    for (genvar g = 0; g < NUM_PIPES; g++) begin : g_pipe
        pipe_collider #(
            .PIPE_WIDTH  (PIPE_WIDTH),
            .BIRD_X      (BIRD_X),
            .BIRD_WIDTH  (BIRD_WIDTH),
            .BIRD_HEIGHT (BIRD_HEIGHT)
        ) u_collider (
            .pipe_x_i   (bus.pipe_x[g*10 +: 10]),
            .gap_top_i  (bus.gap_top[g*10 +: 10]),
            .gap_bot_i  (bus.gap_bot[g*10 +: 10]),
            .bird_y_i   (bus.bird_y),
            .hit_o      (hit_vec[g]),
            .pass_now_o (pass_now[g])
        );
    end

    assign bird_bot   = {1'b0, bus.bird_y} + 11'(BIRD_HEIGHT);
    assign bounds_hit = bird_bot > 11'(SCREEN_HEIGHT);
    assign start_edge = bus.start_button & ~start_q;

    always_comb begin
        state_d     = state_q;
        score_d     = score_q;
        passed_d    = passed_q;
        hit_cnt_d   = '0;
        collision_d = 1'b0;
        pass_cnt    = '0;
        score_sum   = '0;
`ifdef GAME_LIVES_EN
        lives_d     = lives_q;
`endif

        // a pipe that is back to the right of the bird has respawned and may score again
        for (int i = 0; i < NUM_PIPES; i++) begin
            if (!pass_now[i]) passed_d[i] = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                if (start_edge) begin
                    state_d  = PLAY;
                    score_d  = '0;
                    passed_d = '0;
`ifdef GAME_LIVES_EN
                    lives_d  = 2'(LIVES);
`endif
                end
            end
            PLAY: begin
                collision_d = (|hit_vec) | bounds_hit;
                for (int i = 0; i < NUM_PIPES; i++) begin
                    if (pass_now[i] && !passed_q[i]) begin
                        passed_d[i] = 1'b1;
                        pass_cnt    = pass_cnt + SUM_W'(1);
                    end
                end
                score_sum = SUM_W'(score_q) + pass_cnt;
                score_d   = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
                if (collision_q) state_d = HIT;
            end
            HIT: begin
                hit_cnt_d = hit_cnt_q;
                if (bus.frame_tick) begin
                    if (hit_cnt_q == CNT_W'(HIT_FRAMES - 1)) begin
                        hit_cnt_d = '0;
`ifdef GAME_LIVES_EN
                        lives_d   = lives_q - 2'd1;
                        state_d   = (lives_d != 2'd0) ? PLAY : OVER;
`else
                        state_d   = OVER;
`endif
                    end else begin
                        hit_cnt_d = hit_cnt_q + CNT_W'(1);
                    end
                end
            end
            OVER: begin
                if (start_edge) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        game_over_d = (state_d == OVER) && (state_q != OVER);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            collision_q <= 1'b0;
            score_q     <= '0;
            game_over_q <= 1'b0;
            passed_q    <= '0;
            hit_cnt_q   <= '0;
`ifdef GAME_LIVES_EN
            lives_q     <= 2'(LIVES);
`endif
        end else begin
            state_q     <= state_d;
            start_q     <= bus.start_button;
            collision_q <= collision_d;
            score_q     <= score_d;
            game_over_q <= game_over_d;
            passed_q    <= passed_d;
            hit_cnt_q   <= hit_cnt_d;
`ifdef GAME_LIVES_EN
            lives_q     <= lives_d;
`endif
        end
    end

    assign bus.collision_out = collision_q;
    assign bus.state         = state_q;
    assign bus.score         = score_q;
    assign bus.game_over     = game_over_q;
`ifdef GAME_LIVES_EN
    assign bus.lives         = lives_q;
`endif

endmodule

// File: tb/tb_multi_pipe_game_controller.sv
// tb/tb_multi_pipe_game_controller.sv - directed scoreboard bench for multi_pipe_game_controller
// Follows the GAME_LIVES_EN setting of the design build.
module tb_multi_pipe_game_controller;
    import game_pkg::*;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    multi_pipe_game_controller_if #(.NUM_PIPES(3), .SCORE_W(8)) bus ();
    multi_pipe_game_controller_if #(.NUM_PIPES(5), .SCORE_W(2)) bus2 ();

    multi_pipe_game_controller #(.NUM_PIPES(3), .SCORE_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    multi_pipe_game_controller #(.NUM_PIPES(5), .SCORE_W(2)) dut_sat (
        .clk   (clk),
        .reset (reset),
        .bus   (bus2)
    );

    typedef enum int {K_STATE, K_COLL, K_SCORE, K_GO, K_LIVES, K_SCORE2} kind_t;
    typedef struct {
        kind_t kind;
        int    expv;
        string tag;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic push(input kind_t k, input int v, input string tag);
        exp_t e;
        e.kind = k;
        e.expv = v;
        e.tag  = tag;
        sb.push_back(e);
    endtask

    function automatic logic [31:0] observe(input kind_t k);
        case (k)
            K_STATE:  return 32'(bus.state);
            K_COLL:   return 32'(bus.collision_out);
            K_SCORE:  return 32'(bus.score);
            K_GO:     return 32'(bus.game_over);
`ifdef GAME_LIVES_EN
            K_LIVES:  return 32'(bus.lives);
`endif
            K_SCORE2: return 32'(bus2.score);
            default:  return 32'hdead_beef;
        endcase
    endfunction

    task automatic sb_check();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = observe(e.kind);
            checks++;
            assert (obs === 32'(e.expv)) else begin
                failures++;
                $error("FAIL %s: observed=%0d expected=%0d", e.tag, obs, e.expv);
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        sb_check();
    endtask

    task automatic set_pipe(input int idx, input int x, input int top, input int bot);
        bus.pipe_x[idx*10 +: 10]  = 10'(x);
        bus.gap_top[idx*10 +: 10] = 10'(top);
        bus.gap_bot[idx*10 +: 10] = 10'(bot);
    endtask

    task automatic collide(input int by, input string tag);
        set_pipe(0, 90, 190, 290);
        bus.bird_y = 10'(by);
        push(K_COLL, 1, {tag, "_coll"});
        push(K_STATE, 1, {tag, "_still_play"});
        tick();
        bus.bird_y = 10'd200;
        push(K_STATE, 2, {tag, "_to_hit"});
        push(K_COLL, 0, {tag, "_coll_off_in_hit"});
        tick();
    endtask

    task automatic hit_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            bus.frame_tick = 1'b1;
            push(K_STATE, 2, "hit_hold");
            tick();
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bus.start_button  = 1'b0;
        bus.frame_tick    = 1'b0;
        bus.bird_y        = 10'd200;
        bus2.start_button = 1'b0;
        bus2.frame_tick   = 1'b0;
        bus2.bird_y       = 10'd200;
        for (int i = 0; i < 3; i++) set_pipe(i, 600, 0, 1023);
        for (int i = 0; i < 5; i++) begin
            bus2.pipe_x[i*10 +: 10]  = 10'd600;
            bus2.gap_top[i*10 +: 10] = 10'd0;
            bus2.gap_bot[i*10 +: 10] = 10'd1023;
        end

        // reset state
        #1 reset = 1'b0;
        push(K_STATE, 0, "rst_state");
        push(K_COLL, 0, "rst_coll");
        push(K_SCORE, 0, "rst_score");
        push(K_GO, 0, "rst_go");
        push(K_SCORE2, 0, "rst_score2");
`ifdef GAME_LIVES_EN
        push(K_LIVES, 3, "rst_lives");
`endif
        sb_check();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        push(K_STATE, 0, "idle_after_rst");
        tick();

        // start edge: IDLE this cycle, PLAY next
        bus.start_button  = 1'b1;
        bus2.start_button = 1'b1;
        push(K_STATE, 0, "start_same_cycle");
        sb_check();
        push(K_STATE, 1, "start_play");
        push(K_SCORE, 0, "start_score");
        tick();

        // five pipes passing together saturate a 2-bit score
        for (int i = 0; i < 5; i++) bus2.pipe_x[i*10 +: 10] = 10'd40;
        push(K_SCORE2, 3, "sat_score");
        tick();
        push(K_SCORE2, 3, "sat_hold");
        tick();

        // pass scoring
        bus.start_button = 1'b0;
        set_pipe(0, 60, 0, 1023);
        push(K_SCORE, 0, "pass_x60");
        tick();
        set_pipe(0, 49, 0, 1023);
        bus.frame_tick = 1'b1;
        push(K_SCORE, 1, "pass_x49");
        tick();
        bus.frame_tick = 1'b0;
        push(K_SCORE, 1, "pass_hold");
        tick();
        bus.start_button = 1'b1;
        set_pipe(1, 40, 0, 1023);
        set_pipe(2, 40, 0, 1023);
        push(K_SCORE, 3, "pass_two");
        push(K_STATE, 1, "start_ignored_play");
        tick();
        set_pipe(0, 600, 0, 1023);
        push(K_SCORE, 3, "respawn");
        tick();
        set_pipe(0, 49, 0, 1023);
        push(K_SCORE, 4, "repass");
        tick();
        for (int i = 0; i < 3; i++) set_pipe(i, 600, 0, 1023);
        push(K_SCORE, 4, "pipes_away");
        tick();

        // collision edges
        set_pipe(0, 90, 190, 290);
        bus.bird_y = 10'd200;
        push(K_COLL, 0, "in_gap");
        tick();
        bus.bird_y = 10'd270;
        push(K_COLL, 0, "gap_bot_equal");
        tick();
        set_pipe(0, 600, 190, 290);
        bus.bird_y = 10'd460;
        push(K_COLL, 0, "floor_equal");
        tick();
        bus.bird_y = 10'd461;
        push(K_COLL, 1, "floor_hit");
        push(K_STATE, 1, "floor_still_play");
        tick();
        bus.bird_y = 10'd200;
        push(K_STATE, 2, "floor_to_hit");
        push(K_COLL, 0, "coll_off_in_hit");
        tick();

        hit_ticks(29);
`ifdef GAME_LIVES_EN
        push(K_STATE, 1, "hit_exit_play");
        push(K_LIVES, 2, "lives_2");
        push(K_GO, 0, "no_go_play");
        tick();
        bus.frame_tick = 1'b0;
        collide(180, "top");
        hit_ticks(29);
        push(K_STATE, 1, "hit_exit_play2");
        push(K_LIVES, 1, "lives_1");
        tick();
        bus.frame_tick = 1'b0;
        collide(271, "bot");
        hit_ticks(29);
        push(K_LIVES, 0, "lives_0");
`endif
        push(K_STATE, 3, "hit_exit_over");
        push(K_GO, 1, "go_pulse");
        tick();
        bus.frame_tick = 1'b0;
        push(K_STATE, 3, "over_hold");
        push(K_GO, 0, "go_one_cycle");
        tick();

        // OVER -> IDLE -> PLAY restart clears score
        bus.start_button = 1'b0;
        tick();
        bus.start_button = 1'b1;
        push(K_STATE, 0, "over_to_idle");
        push(K_SCORE, 4, "idle_score_kept");
        tick();
        bus.start_button = 1'b0;
        tick();
        bus.start_button = 1'b1;
        push(K_STATE, 1, "restart_play");
        push(K_SCORE, 0, "restart_score");
`ifdef GAME_LIVES_EN
        push(K_LIVES, 3, "restart_lives");
`endif
        tick();

        // async reset in the middle of the HIT phase
        set_pipe(1, 49, 0, 1023);
        push(K_SCORE, 1, "pre_rst_score");
        tick();
        collide(180, "top_b");
        hit_ticks(14);
        bus.frame_tick   = 1'b1;
        bus.start_button = 1'b0;
        #2 reset = 1'b0;
        #1;
        push(K_STATE, 0, "midhit_rst_state");
        push(K_SCORE, 0, "midhit_rst_score");
        push(K_COLL, 0, "midhit_rst_coll");
        sb_check();
        @(negedge clk);
        reset          = 1'b1;
        bus.frame_tick = 1'b0;
        set_pipe(1, 600, 0, 1023);
        bus.start_button = 1'b1;
        push(K_STATE, 1, "post_rst_play");
`ifdef GAME_LIVES_EN
        push(K_LIVES, 3, "post_rst_lives");
`endif
        tick();
        collide(271, "bot_b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
